// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port req/ack arbiter and sequencer for a single-port memory, 3 cycles per access.
// Define MEM_ARB_RR_EN for round-robin tie-break; when undefined port 0 wins every tie.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic                cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic                cur_id_q, cur_id_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
    logic                grant_id;

    // A lone requester wins outright; a tie goes to the port not granted last (RR) or port 0.
    always_comb begin
        if (p0_req && p1_req) begin
            grant_id = RR_EN ? ~last_grant_q : 1'b0;
        end else begin
            grant_id = p1_req;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cur_id_d     = cur_id_q;
        last_grant_d = last_grant_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_d     = ACCESS;
                    cur_id_d    = grant_id;
                    cmd_we_d    = grant_id ? p1_we    : p0_we;
                    cmd_addr_d  = grant_id ? p1_addr  : p0_addr;
                    cmd_wdata_d = grant_id ? p1_wdata : p0_wdata;
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (!cmd_we_q) begin
                    if (cur_id_q) p1_rdata_d = mem_rdata;
                    else          p0_rdata_d = mem_rdata;
                end
            end
            DONE: begin
                state_d      = IDLE;
                last_grant_d = cur_id_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cur_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cur_id_q     <= cur_id_d;
            last_grant_q <= last_grant_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    // Decoded from registers only, so reset clears mem_we without waiting for a clock.
    assign mem_we    = (state_q == ACCESS) && cmd_we_q;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;
    assign busy      = (state_q != IDLE);
    assign p0_ack    = (state_q == DONE) && !cur_id_q;
    assign p1_ack    = (state_q == DONE) && cur_id_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized transactions checked against a slot-level reference model.
// Honours MEM_ARB_RR_EN the same way as the design when predicting tie winners.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory the arbiter drives; the reference keeps its own copy.
    logic [15:0] env_mem [0:65535];
    logic [15:0] ref_mem [0:65535];
    assign mem_rdata = env_mem[mem_addr];
    always @(posedge clk) if (mem_we) env_mem[mem_addr] <= mem_wdata;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    logic [15:0] ref_rdata [2];
    int          ref_last;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic we, input logic [15:0] a, input logic [15:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.data = d;
        if (p == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    task automatic present(input int p);
        if (p == 0) begin
            if (q0.size() > 0) begin
                p0_req = 1'b1; p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].data;
            end else p0_req = 1'b0;
        end else begin
            if (q1.size() > 0) begin
                p1_req = 1'b1; p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].data;
            end else p1_req = 1'b0;
        end
    endtask

    function automatic int pick(input bit want0, input bit want1);
        if (want0 && want1) return RR_EN ? ((ref_last == 0) ? 1 : 0) : 0;
        return want1 ? 1 : 0;
    endfunction

    // Every transaction occupies one 3-cycle slot: ACCESS, DONE (ack), IDLE.
    task automatic run_scenario(input string name);
        int   n;
        int   win;
        txn_t t;
        n   = q0.size() + q1.size();
        win = 0;
        t   = '0;
        present(0);
        present(1);
        for (int c = 1; c <= 3 * n; c++) begin
            @(negedge clk);
            if (c % 3 == 1) begin
                win = pick(q0.size() > 0, q1.size() > 0);
                t   = (win == 0) ? q0[0] : q1[0];
                chk({name, " access mem_we"},    32'(mem_we),    32'(t.we));
                chk({name, " access mem_addr"},  32'(mem_addr),  32'(t.addr));
                chk({name, " access mem_wdata"}, 32'(mem_wdata), 32'(t.data));
                chk({name, " access busy"},      32'(busy),      32'd1);
                chk({name, " access acks"},      32'({p1_ack, p0_ack}), 32'd0);
            end else if (c % 3 == 2) begin
                if (t.we) ref_mem[t.addr] = t.data;
                else      ref_rdata[win]  = ref_mem[t.addr];
                chk({name, " done p0_ack"},   32'(p0_ack),   32'(win == 0));
                chk({name, " done p1_ack"},   32'(p1_ack),   32'(win == 1));
                chk({name, " done p0_rdata"}, 32'(p0_rdata), 32'(ref_rdata[0]));
                chk({name, " done p1_rdata"}, 32'(p1_rdata), 32'(ref_rdata[1]));
                chk({name, " done mem_we"},   32'(mem_we),   32'd0);
                chk({name, " done busy"},     32'(busy),     32'd1);
                ref_last = win;
                if (win == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                present(win);
            end else begin
                chk({name, " idle busy"},   32'(busy),   32'd0);
                chk({name, " idle acks"},   32'({p1_ack, p0_ack}), 32'd0);
                chk({name, " idle mem_we"}, 32'(mem_we), 32'd0);
            end
        end
    endtask

    task automatic do_reset();
        p0_req = 1'b0;
        p1_req = 1'b0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        ref_last     = 1;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
    endtask

    initial begin
        logic [15:0] v;
        int          n0, n1;
        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            v = 16'(i * 40503) ^ 16'h5A5A;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        ref_last     = 1;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;

        repeat (3) @(negedge clk);
        chk("reset p0_ack",    32'(p0_ack),    32'd0);
        chk("reset p1_ack",    32'(p1_ack),    32'd0);
        chk("reset mem_we",    32'(mem_we),    32'd0);
        chk("reset busy",      32'(busy),      32'd0);
        chk("reset mem_addr",  32'(mem_addr),  32'd0);
        chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
        chk("reset p0_rdata",  32'(p0_rdata),  32'd0);
        chk("reset p1_rdata",  32'(p1_rdata),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        push(0, 1'b1, 16'h0012, 16'hBEEF);
        push(0, 1'b0, 16'h0012, 16'h0000);
        run_scenario("wr_rd");
        chk("wr_rd p0_rdata", 32'(p0_rdata), 32'h0000BEEF);

        do_reset();
        push(0, 1'b0, 16'h0003, 16'h0000);
        push(1, 1'b0, 16'h0007, 16'h0000);
        run_scenario("simul");

        for (int i = 0; i < 3; i++) begin
            push(0, i[0], 16'(16'h0020 + i), 16'(16'hA000 + i));
            push(1, ~i[0], 16'(16'h0030 + i), 16'(16'hB000 + i));
        end
        run_scenario("contend");

        push(1, 1'b1, 16'h0050, 16'h1111);
        push(1, 1'b1, 16'h0051, 16'h2222);
        run_scenario("b2b");
        chk("b2b mem 0050", 32'(env_mem[16'h0050]), 32'h00001111);
        chk("b2b mem 0051", 32'(env_mem[16'h0051]), 32'h00002222);

        push(1, 1'b1, 16'h0100, 16'h1234);
        run_scenario("seed");
        push(0, 1'b0, 16'h0100, 16'h0000);
        push(0, 1'b1, 16'h0200, 16'h5555);
        run_scenario("retain");
        chk("retain p0_rdata", 32'(p0_rdata), 32'h00001234);

        push(0, 1'b1, 16'h0040, 16'h7777);
        present(0);
        @(negedge clk);
        chk("abort pre mem_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort mem_we",   32'(mem_we),   32'd0);
        chk("abort busy",     32'(busy),     32'd0);
        chk("abort acks",     32'({p1_ack, p0_ack}), 32'd0);
        chk("abort mem_addr", 32'(mem_addr), 32'd0);
        chk("abort p0_rdata", 32'(p0_rdata), 32'd0);
        p0_req = 1'b0;
        q0.delete();
        @(negedge clk);
        reset = 1'b0;
        ref_last     = 1;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort no ack", 32'({p1_ack, p0_ack}), 32'd0);
        end
        push(0, 1'b1, 16'h0040, 16'h7777);
        push(0, 1'b0, 16'h0040, 16'h0000);
        run_scenario("reissue");
        chk("reissue p0_rdata", 32'(p0_rdata), 32'h00007777);

        for (int s = 0; s < 25; s++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range((n0 == 0) ? 1 : 0, 3);
            for (int i = 0; i < n0; i++)
                push(0, 1'($urandom), 16'(16'hFFF8 + $urandom_range(0, 15)), 16'($urandom));
            for (int i = 0; i < n1; i++)
                push(1, 1'($urandom), 16'(16'hFFF8 + $urandom_range(0, 15)), 16'($urandom));
            run_scenario("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer that shares the single-port 16-bit data memory between two requesters, for example instruction fetch on port 0 and load/store on port 1. It accepts req/ack transactions, grants one per slot, latches the winner's command, drives the memory's write-enable/address/write-data pins, and returns registered read data. It sits between the requesters and the memory and is the only block that drives the memory pins.

## Interface
- `ADDR_W`, 16: address width, passed through unchanged.
- `DATA_W`, 16: data width.

- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `pN_req`  in  1  (N=0,1) transaction request. Held high until `pN_ack`.
- `pN_we`  in  1  1 = write, 0 = read. Stable while `pN_req` is high.
- `pN_addr`  in  ADDR_W  word address. Stable while `pN_req` is high.
- `pN_wdata`  in  DATA_W  write data. Stable while `pN_req` is high.
- `pN_ack`  out  1  one-cycle completion pulse.
- `pN_rdata`  out  DATA_W  registered read result.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  combinational memory read data.
- `busy`  out  1  high in ACCESS and DONE.

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE:**
  - No request: stay in IDLE.
  - Any `pN_req` high: select a winner, then on the edge:
    - latch `we`/`addr`/`wdata` into `cmd_we`/`cmd_addr`/`cmd_wdata`;
    - record the grant in `cur_id`;
    - go to ACCESS.
- **ACCESS:**
  - `mem_addr`=`cmd_addr`, `mem_wdata`=`cmd_wdata`, `mem_we`=`cmd_we`.
  - On the edge:
    - a write commits in memory;
    - a read captures `mem_rdata` into `p<cur_id>_rdata`;
    - go to DONE.
- **DONE:**
  - `p<cur_id>_ack`=1 for exactly this cycle.
  - Go to IDLE.
  - The `last_grant` register is updated to `cur_id`.
- **Driving rules:**
  - `mem_we` is 0 in every state except ACCESS.
  - `mem_addr` and `mem_wdata` always reflect the `cmd_*` registers.
- **Read data retention:**
  - `pN_rdata` changes only on a read completion for port N.
  - Write completions leave it unchanged.
- **Requester rule:**
  - A requester may drop `req` on the edge that ends its ack cycle.
  - `req` still high in the following IDLE is a new transaction.
  - The other port's `ack` never pulses for it.
- **Reset values:**
  - state=IDLE.
  - `p0_ack`, `p1_ack`, `mem_we`, `busy` = 0.
  - `mem_addr`, `mem_wdata`, `p0_rdata`, `p1_rdata` = 0.
  - `last_grant`=1, so port 0 wins the first tie.
- **Reset mid-transaction:**
  - Immediate return to the reset values, including `mem_we`=0 asynchronously.
  - No ack is issued for the aborted transaction; the requester must reissue it.
  - A write aborted in ACCESS may or may not have committed.

## Timing
- Fixed 3-cycle transaction: `req` sampled in IDLE at edge E → ACCESS cycle E..E+1 → `ack` high in cycle E+1..E+2.
- Read data is valid in `pN_rdata` in the same cycle `ack` is high.
- Minimum spacing between grants is 3 cycles; peak throughput is one access per 3 cycles.
- Simultaneous `p0_req` and `p1_req` in IDLE: exactly one wins, chosen by the arbitration policy (see Configuration).
- The loser keeps `req` high and is considered again at the next IDLE.
- Requests arriving during ACCESS/DONE are not sampled until IDLE.
- Addresses wrap naturally at `ADDR_W`; the arbiter performs no range check.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On a tie, the port not equal to `last_grant` wins, so under sustained contention grants alternate 0,1,0,1.
- `MEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. `last_grant` is still maintained, but is unused for selection.

## Test plan
- **Single write then read:** `p0` writes `16'hBEEF` to addr `16'h0012`, then reads the same address.
  - Write: `mem_we`=1 for exactly one cycle; `p0_ack` arrives 2 cycles after grant.
  - Read: `p0_rdata`=`16'hBEEF` with `p0_ack`.
- **Simultaneous requests after reset:** both ports request reads.
  - Port 0 is acked first; port 1 is acked 3 cycles later.
  - `p1_rdata` equals the memory contents at `p1_addr`.
- **Sustained contention, 6 transactions:**
  - With `MEM_ARB_RR_EN`: ack order 0,1,0,1,0,1.
  - Without it: port 0 is serviced continuously while it holds `req`.
- **Back-to-back from one port:** `p1` keeps `req` high across ack with new `addr`/`wdata`.
  - Second transaction granted in the IDLE cycle after DONE.
  - Two distinct writes land in memory.
- **Reset during ACCESS of a write:**
  - `mem_we`, `busy`, `ack` go to 0 immediately; state=IDLE.
  - No ack for the aborted transaction; a reissued request completes normally.
- **Write does not disturb read data:** `p0` reads `16'h1234`, then writes `16'h5555` elsewhere.
  - `p0_rdata` stays `16'h1234` through the write ack.
